// File: rtl/tower_game_engine.sv
// Block-stacking gameplay engine: moves the current block, evaluates drops
// against the previous block, and tracks score, chances and game status.
module tower_game_engine #(
    parameter int SCREEN_W      = 160,
    parameter int SCREEN_H      = 120,
    parameter int X_W           = 8,
    parameter int Y_W           = 7,
    parameter int BLOCK_W0      = 32,
    parameter int BLOCK_H       = 8,
    parameter int MAX_CHANCES   = 3,
    parameter int CH_W          = 4,
    parameter int SCORE_W       = 4,
    parameter int SPEEDUP_EVERY = 4,
    parameter int MAX_STEP      = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               sync,
    input  logic               key,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [X_W-1:0]     w,
    output logic               o,
    output logic [SCORE_W-1:0] score,
    output logic [CH_W-1:0]    chances,
    output logic [1:0]         game_status,
    output logic               drop_done
);

    localparam int XE = X_W + 1;
    localparam int SE = SCORE_W + 1;

    localparam logic [X_W:0]       SCREEN_W_E = XE'(SCREEN_W);
    localparam logic [X_W:0]       MAX_STEP_E = XE'(MAX_STEP);
    localparam logic [X_W-1:0]     BLOCK_W0_X = X_W'(BLOCK_W0);
    localparam logic [X_W-1:0]     BASE_X     = X_W'((SCREEN_W - BLOCK_W0) / 2);
    localparam logic [Y_W-1:0]     SPAWN_Y    = Y_W'(SCREEN_H - 2 * BLOCK_H);
    localparam logic [Y_W-1:0]     BLOCK_H_Y  = Y_W'(BLOCK_H);
    localparam logic [CH_W-1:0]    MAX_CH     = CH_W'(MAX_CHANCES);
    localparam logic [SCORE_W-1:0] SPEED_DIV  = SCORE_W'(SPEEDUP_EVERY);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MOVE = 2'b01,
        S_EVAL = 2'b10,
        S_OVER = 2'b11
    } state_t;

    state_t state, state_nx;

    logic               key_q;
    logic               kedge;
    logic               dir;
    logic [X_W-1:0]     px;
    logic [X_W-1:0]     pw;

    logic [X_W:0]       x_e, w_e, px_e, pw_e;
    logic [X_W:0]       lvl_step, step;
    logic [X_W:0]       right_e, prev_right_e;
    logic [X_W:0]       x_fwd, x_back, x_wall;
    logic [X_W:0]       lft, rgt, ov_w;
    logic               hit, perfect, tower_full;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_nx;
    logic [CH_W-1:0]    chances_dec;

    assign kedge = key & ~key_q;

    assign x_e  = {1'b0, x};
    assign w_e  = {1'b0, w};
    assign px_e = {1'b0, px};
    assign pw_e = {1'b0, pw};

    // Speed grows one pixel per SPEEDUP_EVERY points, capped at MAX_STEP.
    assign lvl_step = XE'(score / SPEED_DIV) + XE'(1);
    assign step     = (lvl_step > MAX_STEP_E) ? MAX_STEP_E : lvl_step;

    assign right_e      = x_e + w_e;
    assign prev_right_e = px_e + pw_e;
    assign x_fwd        = x_e + step;
    assign x_back       = x_e - step;
    assign x_wall       = SCREEN_W_E - w_e;

    assign lft     = (x_e > px_e) ? x_e : px_e;
    assign rgt     = (right_e < prev_right_e) ? right_e : prev_right_e;
    assign hit     = rgt > lft;
    assign ov_w    = rgt - lft;
    assign perfect = (x == px);

    assign score_sum   = {1'b0, score} + (perfect ? SE'(2) : SE'(1));
    assign score_nx    = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
    assign chances_dec = chances - CH_W'(1);
    assign tower_full  = (y < BLOCK_H_Y);

    assign game_status = state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_OVER: begin
                if (kedge) state_nx = S_MOVE;
            end
            S_MOVE: begin
                if (kedge) state_nx = S_EVAL;
            end
            S_EVAL: begin
                if (hit) begin
                    state_nx = tower_full ? S_OVER : S_MOVE;
                end else begin
                    state_nx = (chances_dec == '0) ? S_OVER : S_MOVE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_q     <= 1'b0;
            drop_done <= 1'b0;
            x         <= '0;
            y         <= '0;
            w         <= BLOCK_W0_X;
            o         <= 1'b0;
            score     <= '0;
            chances   <= MAX_CH;
            dir       <= 1'b1;
            px        <= BASE_X;
            pw        <= BLOCK_W0_X;
        end else begin
            key_q     <= key;
            drop_done <= (state == S_EVAL);
            case (state)
                S_IDLE, S_OVER: begin
                    if (kedge) begin
                        score   <= '0;
                        chances <= MAX_CH;
                        o       <= 1'b0;
                        w       <= BLOCK_W0_X;
                        px      <= BASE_X;
                        pw      <= BLOCK_W0_X;
                        x       <= '0;
                        y       <= SPAWN_Y;
                        dir     <= 1'b1;
                    end
                end
                S_MOVE: begin
                    // A drop request wins over a movement tick in the same cycle.
                    if (!kedge && sync) begin
                        if (dir) begin
                            if (right_e + step >= SCREEN_W_E) begin
                                x   <= x_wall[X_W-1:0];
                                dir <= 1'b0;
                            end else begin
                                x <= x_fwd[X_W-1:0];
                            end
                        end else begin
                            if (x_e <= step) begin
                                x   <= '0;
                                dir <= 1'b1;
                            end else begin
                                x <= x_back[X_W-1:0];
                            end
                        end
                    end
                end
                S_EVAL: begin
                    if (hit) begin
                        o     <= 1'b1;
                        px    <= lft[X_W-1:0];
                        pw    <= ov_w[X_W-1:0];
                        w     <= ov_w[X_W-1:0];
                        score <= score_nx;
                        if (!tower_full) begin
                            y   <= y - BLOCK_H_Y;
                            x   <= '0;
                            dir <= 1'b1;
                        end
                    end else begin
                        o       <= 1'b0;
                        chances <= chances_dec;
                        if (chances_dec != '0) begin
                            x   <= '0;
                            dir <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tower_game_engine.sv
// Self-checking bench for tower_game_engine: directed gameplay scenarios plus
// randomized drops, compared against a game-rule model kept in the bench.
module tb_tower_game_engine;

    localparam int SCREEN_W      = 160;
    localparam int SCREEN_H      = 120;
    localparam int X_W           = 8;
    localparam int Y_W           = 7;
    localparam int BLOCK_W0      = 32;
    localparam int BLOCK_H       = 8;
    localparam int MAX_CHANCES   = 3;
    localparam int CH_W          = 4;
    localparam int SCORE_W       = 4;
    localparam int SPEEDUP_EVERY = 4;
    localparam int MAX_STEP      = 4;

    logic               clk    = 1'b0;
    logic               resetn = 1'b1;
    logic               sync   = 1'b0;
    logic               key    = 1'b0;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [X_W-1:0]     w;
    logic               o;
    logic [SCORE_W-1:0] score;
    logic [CH_W-1:0]    chances;
    logic [1:0]         game_status;
    logic               drop_done;

    int checks = 0;
    int passes = 0;

    // Game model: status 0 idle, 1 moving, 2 evaluating, 3 over.
    int m_x, m_y, m_w, m_px, m_pw, m_dir, m_score, m_chances, m_o, m_status, m_dd;

    tower_game_engine #(
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .X_W(X_W), .Y_W(Y_W),
        .BLOCK_W0(BLOCK_W0), .BLOCK_H(BLOCK_H), .MAX_CHANCES(MAX_CHANCES),
        .CH_W(CH_W), .SCORE_W(SCORE_W), .SPEEDUP_EVERY(SPEEDUP_EVERY),
        .MAX_STEP(MAX_STEP)
    ) dut (
        .clk(clk), .resetn(resetn), .sync(sync), .key(key),
        .x(x), .y(y), .w(w), .o(o), .score(score), .chances(chances),
        .game_status(game_status), .drop_done(drop_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    task automatic checkAll(input string where);
        checkOutput({where, ".x"}, int'(x), m_x);
        checkOutput({where, ".y"}, int'(y), m_y);
        checkOutput({where, ".w"}, int'(w), m_w);
        checkOutput({where, ".o"}, int'(o), m_o);
        checkOutput({where, ".score"}, int'(score), m_score);
        checkOutput({where, ".chances"}, int'(chances), m_chances);
        checkOutput({where, ".status"}, int'(game_status), m_status);
        checkOutput({where, ".drop_done"}, int'(drop_done), m_dd);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        m_x = 0; m_y = 0; m_w = BLOCK_W0; m_o = 0; m_score = 0;
        m_chances = MAX_CHANCES; m_status = 0; m_dd = 0; m_dir = 1;
        m_px = (SCREEN_W - BLOCK_W0) / 2; m_pw = BLOCK_W0;
    endtask

    task automatic modelStart();
        m_score = 0; m_chances = MAX_CHANCES; m_o = 0; m_w = BLOCK_W0;
        m_px = (SCREEN_W - BLOCK_W0) / 2; m_pw = BLOCK_W0;
        m_x = 0; m_y = SCREEN_H - 2 * BLOCK_H; m_dir = 1; m_status = 1;
    endtask

    task automatic modelMove();
        int step;
        step = 1 + m_score / SPEEDUP_EVERY;
        if (step > MAX_STEP) step = MAX_STEP;
        if (m_dir == 1) begin
            if (m_x + m_w + step >= SCREEN_W) begin
                m_x = SCREEN_W - m_w; m_dir = 0;
            end else m_x = m_x + step;
        end else begin
            if (m_x <= step) begin
                m_x = 0; m_dir = 1;
            end else m_x = m_x - step;
        end
    endtask

    task automatic modelDrop();
        int l, r, bonus, smax;
        l = (m_x > m_px) ? m_x : m_px;
        r = (m_x + m_w < m_px + m_pw) ? m_x + m_w : m_px + m_pw;
        smax = (1 << SCORE_W) - 1;
        if (r > l) begin
            bonus = (m_x == m_px) ? 2 : 1;
            m_o = 1; m_w = r - l; m_px = l; m_pw = r - l;
            m_score = (m_score + bonus > smax) ? smax : m_score + bonus;
            if (m_y < BLOCK_H) m_status = 3;
            else begin
                m_y = m_y - BLOCK_H; m_x = 0; m_dir = 1; m_status = 1;
            end
        end else begin
            m_o = 0; m_chances = m_chances - 1;
            if (m_chances == 0) m_status = 3;
            else begin
                m_x = 0; m_dir = 1; m_status = 1;
            end
        end
    endtask

    task automatic doSync();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        if (m_status == 1) modelMove();
        checkAll("sync");
    endtask

    task automatic applyStimulus(input int hold, input bit with_sync);
        key = 1'b1;
        sync = with_sync;
        tick();
        sync = 1'b0;
        if (m_status == 0 || m_status == 3) begin
            modelStart();
            checkAll("start");
            key = (hold >= 2);
            tick();
            checkAll("start_hold");
        end else begin
            m_status = 2;
            checkAll("eval");
            key = (hold >= 2);
            sync = 1'($urandom_range(0, 1));
            tick();
            sync = 1'b0;
            modelDrop();
            m_dd = 1;
            checkAll("drop");
            m_dd = 0;
            key = (hold >= 3);
            tick();
            checkAll("post_drop");
        end
        key = 1'b0;
        tick();
        checkAll("release");
    endtask

    task automatic aimAndDrop(input int target, input int budget);
        int n;
        n = 0;
        while (m_x != target && n < budget && m_status == 1) begin
            doSync();
            n++;
        end
        applyStimulus(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        modelReset();
        #1 resetn = 1'b0;
        #3 checkAll("reset");
        tick();
        resetn = 1'b1;
        doSync();

        applyStimulus(1, 1'b0);
        checkOutput("spawn_y", int'(y), 104);

        for (int i = 0; i < 128; i++) doSync();
        checkOutput("right_wall_x", int'(x), 128);
        doSync();
        checkOutput("bounce_x", int'(x), 127);

        aimAndDrop(64, 200);
        checkOutput("perfect_score", int'(score), 2);
        checkOutput("perfect_y", int'(y), 96);

        aimAndDrop(70, 200);
        checkOutput("partial_w", int'(w), 26);
        aimAndDrop(60, 200);
        checkOutput("shrink_w", int'(w), 16);
        checkOutput("shrink_score", int'(score), 4);

        doSync();
        checkOutput("speed2_x", int'(x), 2);
        doSync();

        // Asynchronous reset mid-move with key held across the release.
        key = 1'b1;
        resetn = 1'b0;
        modelReset();
        #2 checkAll("async_reset");
        tick();
        checkAll("in_reset");
        resetn = 1'b0;
        #0 resetn = 1'b1;
        tick();
        modelStart();
        checkAll("held_key_start");
        key = 1'b0;
        tick();
        checkAll("held_key_release");

        for (int i = 0; i < 3; i++) aimAndDrop(0, 10);
        checkOutput("miss_chances", int'(chances), 0);
        checkOutput("miss_status", int'(game_status), 3);
        doSync();
        applyStimulus(1, 1'b0);
        checkOutput("restart_chances", int'(chances), MAX_CHANCES);

        for (int i = 0; i < 80; i++) begin
            if (m_status != 1) applyStimulus(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
            else if ($urandom_range(0, 9) < 7) aimAndDrop(m_px, 400);
            else aimAndDrop(int'($urandom_range(0, SCREEN_W - m_w)), 400);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tower_game_engine.md
# tower_game_engine

Parametrised gameplay engine for the block-stacking game. It merges gameplay control and datapath into a single synthesizable block and adds several behaviours: configurable screen and block geometry, block shrinking on partial overlap, a perfect-drop bonus, speed-up with score, and tower-full game end. It sits between the delay counter (`sync`) and the key input on one side and the display FSM on the other. It drives block position and size, score, chances and status.

## Interface
- `SCREEN_W`, 160: playfield width in pixels
- `SCREEN_H`, 120: playfield height in pixels
- `X_W`, 8: width of x / block-width buses
- `Y_W`, 7: width of y bus
- `BLOCK_W0`, 32: initial block width
- `BLOCK_H`, 8: block height
- `MAX_CHANCES`, 3: chances per game
- `CH_W`, 4: chances bus width
- `SCORE_W`, 4: score bus width
- `SPEEDUP_EVERY`, 4: score points per speed level
- `MAX_STEP`, 4: maximum pixels moved per `sync`

Ports:
- `clk`  in  1  system clock (50 MHz); the only clock
- `resetn`  in  1  reset, asynchronous, active-low
- `sync`  in  1  one-cycle movement tick from the delay counter
- `key`  in  1  drop/start request, active-high, already synchronised to `clk`
- `x`  out  X_W  left edge of the moving block
- `y`  out  Y_W  top row of the moving block
- `w`  out  X_W  current block width
- `o`  out  1  overlap result of the last drop
- `score`  out  SCORE_W  player score, saturating
- `chances`  out  CH_W  remaining chances
- `game_status`  out  2  00 idle, 01 moving, 10 evaluating, 11 over
- `drop_done`  out  1  one-cycle pulse when the drop results are updated

## Operation
- Key edge: `key_q` is registered and resets to 0. `kedge = key & ~key_q`. A key held through reset release therefore yields one edge.
- Internal state: previous block `px`/`pw`, `dir` (1 = right), state register.
- Base block: `px = (SCREEN_W-BLOCK_W0)/2`, `pw = BLOCK_W0`. It is not output.
- Start (init):
  - Taken on `kedge` in IDLE or OVER.
  - Sets `score=0`, `chances=MAX_CHANCES`, `o=0`, `w=BLOCK_W0`.
  - Resets `px`/`pw` to the base block.
  - Spawns the block at `x=0`, `y=SCREEN_H-2*BLOCK_H`, `dir=1`, then goes to MOVE.
- MOVE:
  - Step size: `step = min(1 + score/SPEEDUP_EVERY, MAX_STEP)`.
  - On `sync`, with `dir=1`: if `x+w+step >= SCREEN_W`, set `x=SCREEN_W-w` and `dir=0`; else `x+=step`.
  - On `sync`, with `dir=0`: if `x <= step`, set `x=0` and `dir=1`; else `x-=step`.
  - All sums are computed at X_W+1 bits.
  - On `kedge`, go to EVAL. `kedge` has priority: a `sync` in the same cycle is discarded.
- EVAL (one cycle): compute `L = max(x,px)` and `R = min(x+w, px+pw)`.
  - Hit (`R > L`):
    - `o=1`, `pw=R-L`, `px=L`, `w=R-L`.
    - `score += (x==px) ? 2 : 1`, saturating at 2^SCORE_W-1.
    - If `y < BLOCK_H`, go to OVER (tower full) and leave `y` unchanged. Otherwise set `y -= BLOCK_H`, respawn at `x=0` with `dir=1`, and go to MOVE.
  - Miss:
    - `o=0`, `chances -= 1`.
    - If the new value is 0, go to OVER. Otherwise respawn at `x=0`, `dir=1`, with the same `y` and `w`, and go to MOVE.
- OVER: all outputs hold. `kedge` triggers a start.
- `drop_done` pulses for the cycle immediately after EVAL.

## Timing
- Reset values (asynchronous): `x=0`, `y=0`, `w=BLOCK_W0`, `o=0`, `score=0`, `chances=MAX_CHANCES`, `game_status=00`, `drop_done=0`, `dir=1`, `key_q=0`, `px`/`pw` = base block.
- Start: `key` high at edge n, with `key_q` low, gives MOVE and the spawn outputs at edge n+1.
- Movement: `sync` at edge n updates `x` at edge n+1.
- Drop:
  - `kedge` at edge n: `game_status=10` from n+1.
  - Results (`o`, `score`, `chances`, `x`/`y`/`w`) and the new state are visible from n+2, with `drop_done=1` for exactly that cycle.
- A `key` held high produces one edge only. `key` must go low for at least one cycle before the next edge.
- Asserting `resetn` mid-game returns all outputs to their reset values immediately, with no clock needed.

## Test plan
- Reset then key pulse: outputs `x=0`, `y=104`, `w=32`, `chances=3`, `score=0`, `status=01`.
- 128 `sync` pulses → `x=128`, `dir` flips; next `sync` → `x=127`.
- Perfect drop at `x=64` → `o=1`, `score=2`, `y=96`, `w=32`, `x=0`, one `drop_done` pulse.
- Drop at `x=70` on the base → `o=1`, `score=1`, `w=26`, `px=70`. Then a drop at `x=60` → `w=16`, `px=70`.
- Three drops at `x=0` → `chances` 2, 1, 0, `o=0`, `status=11`. Then a key pulse → new game with `chances=3`, `score=0`.
- `score=4` → `x` advances 2 per `sync`. Reset asserted mid-MOVE → all reset values immediately; `key` + `sync` in the same cycle → EVAL with `x` unchanged.
